// File: rtl/popcount_neuron_pkg.sv
// Shared types and constants for the ternary popcount neuron sequencer.
// Holds the FSM state encoding, activation codes and accumulator sizing.
package popcount_neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    // A 4-bit core result can reach 15 per chunk, so size for 15*n_chunks.
    function automatic int acc_width(input int n_chunks);
        return $clog2(15 * n_chunks + 1);
    endfunction

endpackage

// File: rtl/popcount_neuron_seq_core.sv
// Approximate 10-input popcount: bits [7:0] are counted exactly, the top pair
// collapses to a single OR term weighted 3, so the result spans 0..11.
module popcount10_approx (
    input  logic [9:0] input_a,
    output logic [3:0] out
);

    logic [3:0] low_cnt;

    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            low_cnt = low_cnt + {3'b000, input_a[i]};
        end
    end

    assign out = low_cnt + ((input_a[9] | input_a[8]) ? 4'd3 : 4'd0);

endmodule

// File: rtl/popcount_neuron_seq.sv
// Time-multiplexed ternary neuron: one shared popcount core walks the pos/neg
// chunks, then (pos - neg) is thresholded. Define POPCOUNT_EXACT_EN for an exact core.
module popcount_neuron_seq
    import popcount_neuron_pkg::*;
#(
    parameter int        N_CHUNKS = 4,
    parameter int signed THR_HI   = 2,
    parameter int signed THR_LO   = -2,
    localparam int       AW       = acc_width(N_CHUNKS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [10*N_CHUNKS-1:0] in_pos,
    input  logic [10*N_CHUNKS-1:0] in_neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_act,
    output logic [AW:0]            out_diff
);

    localparam int VW = 10 * N_CHUNKS;
    localparam int IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int DW = AW + 1;
    localparam logic signed [DW-1:0] THR_HI_W = DW'(THR_HI);
    localparam logic signed [DW-1:0] THR_LO_W = DW'(THR_LO);

    state_t                state, state_next;
    logic [VW-1:0]         pos_reg, neg_reg;
    logic [IW-1:0]         idx;
    logic [AW-1:0]         pos_acc, neg_acc, neg_sum, core_ext;
    logic [9:0]            core_in;
    logic [3:0]            core_out;
    logic                  last;
    logic signed [DW-1:0]  diff_next;
    logic [1:0]            act_next;

    assign last = (idx == IW'(N_CHUNKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Core input is held at zero outside POS/NEG so the core stays quiet.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_in    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = POS;
            end
            POS: begin
                core_in    = pos_reg[idx*10 +: 10];
                state_next = NEG;
            end
            NEG: begin
                core_in    = neg_reg[idx*10 +: 10];
                state_next = last ? DONE : POS;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef POPCOUNT_EXACT_EN
    always_comb begin
        core_out = '0;
        for (int i = 0; i < 10; i++) begin
            core_out = core_out + {3'b000, core_in[i]};
        end
    end
`else
    popcount10_approx u_core (
        .input_a (core_in),
        .out     (core_out)
    );
`endif

    assign core_ext = {{(AW-4){1'b0}}, core_out};
    assign neg_sum  = neg_acc + core_ext;

    // Result is taken on the edge that enters DONE, folding in the final neg chunk.
    assign diff_next = signed'({1'b0, pos_acc}) - signed'({1'b0, neg_sum});

    always_comb begin
        act_next = ACT_ZERO;
        if (diff_next > THR_HI_W)      act_next = ACT_POS;
        else if (diff_next < THR_LO_W) act_next = ACT_NEG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg  <= '0;
            neg_reg  <= '0;
            idx      <= '0;
            pos_acc  <= '0;
            neg_acc  <= '0;
            out_diff <= '0;
            out_act  <= ACT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pos_reg <= in_pos;
                        neg_reg <= in_neg;
                        pos_acc <= '0;
                        neg_acc <= '0;
                        idx     <= '0;
                    end
                end
                POS: pos_acc <= pos_acc + core_ext;
                NEG: begin
                    neg_acc <= neg_sum;
                    if (last) begin
                        out_diff <= diff_next;
                        out_act  <= act_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_neuron_seq.sv
// Bench for popcount_neuron_seq: directed literal cases plus random vectors,
// all results scored against a chunk-level arithmetic model of the neuron.
module tb_popcount_neuron_seq;

    localparam int N   = 4;
    localparam int W   = 10 * N;
    localparam int AW  = $clog2(15 * N + 1);
    localparam int THI = 2;
    localparam int TLO = -2;

    typedef struct {
        int diff;
        int act;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_pos = '0;
    logic [W-1:0]  in_neg = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_act;
    logic [AW:0]   out_diff;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   prev_valid = 1'b0;
    res_t exp_q[$];

    popcount_neuron_seq #(.N_CHUNKS(N), .THR_HI(THI), .THR_LO(TLO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_diff  (out_diff)
    );

    always #5 clk = ~clk;

    function automatic int core_ref(input logic [9:0] c);
`ifdef POPCOUNT_EXACT_EN
        return $countones(c);
`else
        logic [7:0] lo;
        lo = c[7:0];
        return $countones(lo) + ((c[9] || c[8]) ? 3 : 0);
`endif
    endfunction

    function automatic res_t model(input logic [W-1:0] p, input logic [W-1:0] n);
        res_t r;
        r.diff = 0;
        for (int i = 0; i < N; i++) begin
            r.diff += core_ref(p[i*10 +: 10]) - core_ref(n[i*10 +: 10]);
        end
        r.act = (r.diff > THI) ? 1 : (r.diff < TLO) ? 3 : 0;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] a, b, c;
        a = W'({$urandom, $urandom});
        b = W'({$urandom, $urandom});
        c = W'({$urandom, $urandom});
        case ($urandom_range(0, 3))
            0: return a;
            1: return a & b;
            2: return a & b & c;
            default: return a | b;
        endcase
    endfunction

    // Scoreboard: push model result on accept, compare every cycle out_valid is high.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        if (!prev_valid) check("latency", cyc - acc_cyc, 2 * N + 1);
                        check("sb_diff", int'($signed(out_diff)), exp_q[0].diff);
                        check("sb_act", int'(out_act), exp_q[0].act);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_valid = out_valid && !out_ready;
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_pos, in_neg));
                    acc_cyc = cyc;
                end
            end
        end
    end

    // Inputs are scrambled right after acceptance; the result must not see it.
    task automatic send(input logic [W-1:0] p, input logic [W-1:0] n);
        int t = 0;
        in_pos   = p;
        in_neg   = n;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pos   = rand_vec();
        in_neg   = rand_vec();
    endtask

    task automatic wait_result(output int d, output int a);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
        d = int'($signed(out_diff));
        a = int'(out_act);
    endtask

    task automatic directed(input string name, input logic [W-1:0] p,
                            input logic [W-1:0] n, input int ed, input int ea);
        int d, a;
        send(p, n);
        wait_result(d, a);
        check({name, "_diff"}, d, ed);
        check({name, "_act"}, a, ea);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, a;
        logic [W-1:0] v;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_diff", int'(out_diff), 0);
        check("rst_out_act", int'(out_act), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef POPCOUNT_EXACT_EN
        directed("all_pos", 40'hFF_FFFF_FFFF, '0, 40, 1);
        directed("neg_chunk0", '0, 40'h3FF, -10, 3);
`else
        directed("all_pos", 40'hFF_FFFF_FFFF, '0, 44, 1);
        directed("neg_chunk0", '0, 40'h3FF, -11, 3);
`endif
        directed("diff_p1", 40'h3, 40'h1, 1, 0);
        directed("diff_p2", 40'h10_0400, '0, 2, 0);
        directed("diff_m2", '0, 40'h00_4000_0001, -2, 0);
        directed("diff_p3", 40'h7, '0, 3, 1);
        directed("diff_m3", 40'h1, 40'hF, -3, 3);

        // Stall in DONE: outputs hold, then release returns to IDLE next cycle.
        out_ready = 1'b0;
        send(40'hF, 40'h1);
        wait_result(d, a);
        check("stall_diff0", d, 3);
        check("stall_act0", a, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_diff", int'($signed(out_diff)), 3);
            check("stall_act", int'(out_act), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
        directed("after_stall", '0, 40'hFF, -8, 3);

        // Abort during NEG of chunk 2 with an async reset.
        send(40'hFF_FFFF_FFFF, 40'h1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_diff", int'(out_diff), 0);
        check("abort_out_act", int'(out_act), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("post_abort", 40'h3F, 40'h3, 4, 1);

        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 4) != 0);
            v = rand_vec();
            send(v, rand_vec());
            wait_result(d, a);
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
